count_seq_checker: RTL and testbench

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

---
 rtl/count_seq_checker.sv | 158 +++++++++++++++
 tb/tb_count_seq_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto a free-running mod-8 up-count stream.
// It hunts for a start value, confirms LOCK_N consecutive in-sequence samples,
// then flywheels the expected count. While locked it flags mismatches (err),
// flags in-sequence 7s (wrap) and counts errors (saturating).
// Lock is dropped after LOSS_N consecutive mismatches.
module count_seq_checker #(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] inp,
    input  logic       in_valid,
    output logic       locked,
    output logic       err,
    output logic       wrap,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_N);
    localparam logic [3:0] LOSS_C = 4'(LOSS_N);

    // Modulo-8 successor; any carry out of bit 2 is dropped.
    function automatic logic [2:0] inc3(input logic [2:0] v);
        return v + 3'd1;
    endfunction

    state_t     state_r, state_s;
    logic [2:0] expected_r, expected_s;
    logic [3:0] match_cnt_r, match_cnt_s;
    logic [3:0] miss_cnt_r, miss_cnt_s;
    logic       locked_r, err_r, wrap_r;
    logic [7:0] err_count_r;
    logic       err_s, wrap_s, hit_s;

    assign hit_s = (inp == expected_r);

    // Next-state, next-counter and pulse decode for one valid sample.
    always_comb begin
        state_s     = state_r;
        expected_s  = expected_r;
        match_cnt_s = match_cnt_r;
        miss_cnt_s  = miss_cnt_r;
        err_s       = 1'b0;
        wrap_s      = 1'b0;
        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    expected_s  = inc3(inp);
                    match_cnt_s = 4'd1;
                    state_s     = CHECK;
                end
                CHECK: begin
                    expected_s = inc3(inp);
                    if (hit_s) begin
                        match_cnt_s = match_cnt_r + 4'd1;
                        if ((match_cnt_r + 4'd1) == LOCK_C) begin
                            state_s    = LOCKED;
                            miss_cnt_s = 4'd0;
                        end else begin
                            state_s = CHECK;
                        end
                    end else begin
                        // Resynchronise on the new value; no error while acquiring.
                        match_cnt_s = 4'd1;
                    end
                end
                LOCKED: begin
                    // Flywheel: expected advances whether or not the sample matched.
                    expected_s = inc3(expected_r);
                    if (hit_s) begin
                        wrap_s = (inp == 3'd7);
                    end else begin
                        err_s      = 1'b1;
                        miss_cnt_s = 4'd1;
                        if (LOSS_C == 4'd1) begin
                            state_s     = HUNT;
                            match_cnt_s = 4'd0;
                            miss_cnt_s  = 4'd0;
                        end else begin
                            state_s = SLIP;
                        end
                    end
                end
                SLIP: begin
                    expected_s = inc3(expected_r);
                    if (hit_s) begin
                        wrap_s     = (inp == 3'd7);
                        miss_cnt_s = 4'd0;
                        state_s    = LOCKED;
                    end else begin
                        err_s      = 1'b1;
                        miss_cnt_s = miss_cnt_r + 4'd1;
                        if ((miss_cnt_r + 4'd1) == LOSS_C) begin
                            state_s     = HUNT;
                            match_cnt_s = 4'd0;
                            miss_cnt_s  = 4'd0;
                        end else begin
                            state_s = SLIP;
                        end
                    end
                end
                default: begin
                    state_s     = HUNT;
                    expected_s  = 3'd0;
                    match_cnt_s = 4'd0;
                    miss_cnt_s  = 4'd0;
                end
            endcase
        end else if (state_r != HUNT && state_r != CHECK &&
                     state_r != LOCKED && state_r != SLIP) begin
            // Illegal encodings recover even without a valid sample.
            state_s = HUNT;
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs; synchronous reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= HUNT;
            expected_r  <= 3'd0;
            match_cnt_r <= 4'd0;
            miss_cnt_r  <= 4'd0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            wrap_r      <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            expected_r  <= expected_s;
            match_cnt_r <= match_cnt_s;
            miss_cnt_r  <= miss_cnt_s;
            locked_r    <= (state_s == LOCKED) || (state_s == SLIP);
            err_r       <= err_s;
            wrap_r      <= wrap_s;
            if (err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign locked    = locked_r;
    assign err       = err_r;
    assign wrap      = wrap_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker (LOCK_N=4, LOSS_N=2).
// Each stimulus step pushes the expected registered outputs; the monitor pops
// one entry per clock, one edge later, and compares.
module tb_count_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] inp = 3'd0;
    logic       in_valid = 1'b0;
    logic       locked, err, wrap;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    int step_no = 0;
    int mon_no = 0;

    typedef struct packed {
        logic       l;
        logic       e;
        logic       w;
        logic [7:0] c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    count_seq_checker #(.LOCK_N(4), .LOSS_N(2)) dut (
        .clk(clk),
        .reset(reset),
        .inp(inp),
        .in_valid(in_valid),
        .locked(locked),
        .err(err),
        .wrap(wrap),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and record the response due after the next edge.
    task automatic step(input logic rst, input logic v, input logic [2:0] d,
                        input logic l, input logic e, input logic w,
                        input logic [7:0] c);
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        inp      = d;
        step_no++;
        sb_q.push_back({l, e, w, c});
    endtask

    // Monitor: compare outputs against the oldest expectation after each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            mon_no++;
            checks++;
            if ({locked, err, wrap, err_count} !== mon_x) begin
                failures++;
                $display("FAIL outputs step=%0d got locked=%b err=%b wrap=%b cnt=%0d want locked=%b err=%b wrap=%b cnt=%0d",
                         mon_no, locked, err, wrap, err_count,
                         mon_x.l, mon_x.e, mon_x.w, mon_x.c);
            end
        end
    end

    initial begin
        logic [2:0] e;
        logic [2:0] m;
        int         cnt;

        // Reset state
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);

        // Lock on 0,1,2,3
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0);

        // Wrap: 4, then 5,6,7,0 with a single wrap pulse after 7
        step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Advance to expecting 4, then glitch: 4,6,6,7
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'd1);

        // Loss: reach expecting 2, then 5,5 drops lock (count is cumulative)
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd1);
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 8'd2);
        step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'd3);

        // Hunt sample 1 enters CHECK, then 2; gap of 3 idle cycles
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 8'd3);

        // Resync on 6, then 7,0,1 locks; no wrap or err while acquiring
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd3);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'd3);

        // Idle while locked: everything holds, a wrong inp is ignored
        step(1'b0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 8'd3);

        // Saturation: alternate mismatch / flywheel match, 300 errors total
        e   = 3'd2;
        cnt = 3;
        for (int i = 0; i < 300; i++) begin
            m   = e ^ 3'b100;
            cnt = (cnt < 255) ? cnt + 1 : 255;
            step(1'b0, 1'b1, m, 1'b1, 1'b1, 1'b0, 8'(cnt));
            e = e + 3'd1;
            step(1'b0, 1'b1, e, 1'b1, 1'b0, (e == 3'd7), 8'(cnt));
            e = e + 3'd1;
        end

        // One more error into SLIP at saturation, then reset mid-SLIP
        m = e ^ 3'b100;
        step(1'b0, 1'b1, m, 1'b1, 1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b1, e + 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);

        // First sample after reset is a HUNT sample; 5,6,7,0 relocks
        step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
